// File: rtl/error_estimator_pkg.sv
// Shared definitions for the error_estimator block: default fixed-point
// geometry, the Q-format unit constant and the control FSM state encoding.
package estimator_pkg;

    localparam int WIDTH_DEF = 20;
    localparam int FRAC_DEF  = 10;
    localparam int CNT_W_DEF = 8;

    // 1.0 in the default Q format
    localparam int ONE = 1 << FRAC_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/error_estimator_qmul.sv
// Signed fixed-point multiply followed by an arithmetic right shift by FRAC.
// The full 2*WIDTH product is formed first; the result is truncated to OUT_W
// bits, so OUT_W = WIDTH gives ordinary wrapping Q arithmetic and
// OUT_W = 2*WIDTH keeps the whole shifted product.
module qmul #(
    parameter int WIDTH = 20,
    parameter int FRAC  = 10,
    parameter int OUT_W = WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [OUT_W-1:0] q
);

    logic signed [2*WIDTH-1:0] prod;

    // Full-precision product, then shift and truncate to the output width
    always_comb begin
        prod = a * b;
        q    = OUT_W'(prod >>> FRAC);
    end

endmodule

// File: rtl/error_estimator.sv
// error_estimator: streams (x, y) samples through a two-stage pipeline and
// accumulates the sum of squared residuals y - (b0 + b1*x) in Q format.
//
// Optional feature: define ERROR_ESTIMATOR_SAT_EN to make the sse
// accumulator saturate at the largest positive WIDTH-bit value instead of
// wrapping modulo 2^WIDTH.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in RUN; the source may drop in_valid at any time
// (bubbles), and x/y/in_last are only looked at on transfer cycles.
module error_estimator
    import estimator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_last,
    output logic [WIDTH-1:0] sse,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

`ifdef ERROR_ESTIMATOR_SAT_EN
    // keep the whole square so an out-of-range term still saturates
    localparam int SQ_W = 2 * WIDTH;
`else
    localparam int SQ_W = WIDTH;
`endif

    state_t                  state;
    logic                    drain_cnt;
    logic signed [WIDTH-1:0] b0_q;
    logic signed [WIDTH-1:0] b1_q;

    logic                    take;
    logic signed [WIDTH-1:0] bx;
    logic signed [WIDTH-1:0] yhat;
    logic signed [WIDTH-1:0] err_c;

    logic                    v1;
    logic signed [WIDTH-1:0] err_q;
    logic signed [SQ_W-1:0]  sq;
    logic [WIDTH-1:0]        sse_next;

    assign take      = in_valid && in_ready;
    assign dbg_state = state;

    qmul #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(WIDTH)) u_bx (
        .a (b1_q),
        .b ($signed(x)),
        .q (bx)
    );

    qmul #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(SQ_W)) u_sq (
        .a (err_q),
        .b (err_q),
        .q (sq)
    );

    // Stage 1 combinational: prediction and residual for the sample on the bus
    always_comb begin
        yhat  = b0_q + bx;
        err_c = $signed(y) - yhat;
    end

`ifdef ERROR_ESTIMATOR_SAT_EN
    localparam logic [SQ_W:0] SSE_MAX = {{(SQ_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
    logic [SQ_W:0] sum_ext;

    // Saturating accumulate; sse never exceeds SSE_MAX so the sum cannot overflow
    always_comb begin
        sum_ext  = {1'b0, sq} + {{(SQ_W + 1 - WIDTH){1'b0}}, sse};
        sse_next = (sum_ext > SSE_MAX) ? SSE_MAX[WIDTH-1:0] : sum_ext[WIDTH-1:0];
    end
`else
    // Wrapping accumulate modulo 2^WIDTH
    always_comb begin
        sse_next = sse + $unsigned(sq);
    end
`endif

    // Control FSM with registered handshake/status outputs and coefficient latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            b0_q      <= '0;
            b1_q      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        b0_q     <= $signed(b0);
                        b1_q     <= $signed(b1);
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (take && in_last) begin
                        state     <= DRAIN;
                        in_ready  <= 1'b0;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    // two cycles let the last sample leave both stages
                    if (drain_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: residual register, sample counter and sse accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            err_q <= '0;
            count <= '0;
            sse   <= '0;
        end else if (state == IDLE && start) begin
            v1    <= 1'b0;
            err_q <= '0;
            count <= '0;
            sse   <= '0;
        end else begin
            v1 <= take;
            if (take) begin
                err_q <= err_c;
                if (count != {CNT_W{1'b1}}) begin
                    count <= count + CNT_W'(1);
                end
            end
            if (v1) begin
                sse <= sse_next;
            end
        end
    end

endmodule

// File: doc/error_estimator.md
ERROR_ESTIMATOR -- requirements
Module: error_estimator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, data width of all fixed-point values.
REQ-002 The block SHALL have parameter FRAC, default 10, fractional bits (signed two's-complement Q10.10 at defaults).
REQ-003 The block SHALL have parameter CNT_W, default 8, width of the sample counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-006 start  input  1  one-cycle pulse; latches b0/b1 and begins a pass.
REQ-007 b0, b1  input  WIDTH each  intercept and slope from the coefficient stage (registered outputs).
REQ-008 in_valid  input  1  x/y/in_last are valid this cycle.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 x, y  input  WIDTH each  sample pair, Q format.
REQ-011 in_last  input  1  marks the final sample of the pass.
REQ-012 sse  output  WIDTH  sum of squared residuals, Q format.
REQ-013 count  output  CNT_W  number of samples accepted in the pass.
REQ-014 busy  output  1  high from start until done.
REQ-015 done  output  1  one-cycle pulse when sse/count are final.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE -> RUN on start; b0/b1 latched, accumulator and count cleared in that same cycle.
REQ-018 start SHALL be ignored in any state other than IDLE.
REQ-019 in_ready SHALL be 1 only in RUN; a sample transfers when in_valid && in_ready.
REQ-020 Stage 1 (transfer cycle + 1): yhat = b0 + ((b1*x) >>> FRAC), full 2*WIDTH product, truncated to WIDTH after shift; err = y - yhat.
REQ-021 Stage 2 (+2): sq = (err*err) >>> FRAC; sse <= sse + sq.
REQ-022 count SHALL increment on each transfer and hold at 2^CNT_W-1 (no wrap).
REQ-023 RUN -> DRAIN on the transfer carrying in_last; in_ready low from the next cycle.
REQ-024 DRAIN SHALL last exactly 2 cycles (pipeline flush), then -> DONE.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE; sse and count hold until the next start.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 Gaps in in_valid SHALL stall nothing but insert bubbles; the result SHALL be independent of gap pattern.
REQ-028 Latency from in_last transfer to done SHALL be 3 cycles.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, clear both pipeline stages, and set sse=0, count=0, in_ready=0, busy=0, done=0, latched b0/b1=0.
REQ-030 Reset mid-pass SHALL discard the pass; no done pulse SHALL follow.

Configuration
REQ-031 Macro ERROR_ESTIMATOR_SAT_EN: when defined, the sse accumulation SHALL saturate at the maximum positive WIDTH-bit value (sq is non-negative, so no negative bound); when undefined, accumulation SHALL wrap modulo 2^WIDTH.

Structure
REQ-032 Package estimator_pkg SHALL hold WIDTH/FRAC defaults, the FSM state enum, and the Q-format ONE constant (1 << FRAC).
REQ-033 One sub-module qmul SHALL implement the signed fixed-point multiply-and-shift and be instantiated twice (b1*x, err*err).

Verification
REQ-034 b0=0, b1=20'h00400 (1.0), x=y for 4 samples (1.0, 2.0, 3.0, 4.0) -> sse=0, count=4, done 3 cycles after last.
REQ-035 b0=20'h00400, b1=0, y=20'h00C00 (3.0) x 3 samples -> err=2.0 each, sse=20'h03000 (12.0), count=3.
REQ-036 Same as REQ-035 with in_valid toggling every other cycle -> identical sse/count; in_ready low in DRAIN/DONE.
REQ-037 Large residuals (err=20'h3FC00) x 4 -> sse saturates at 20'h7FFFF with ERROR_ESTIMATOR_SAT_EN, wraps without.
REQ-038 rst low during RUN after 2 samples -> all outputs 0 next observation, no done; subsequent start runs a clean pass.
REQ-039 start pulsed during RUN -> ignored; b0/b1 unchanged, pass completes normally.
